// File: rtl/data_bus_responder.sv
// data_bus_responder: memory-mapped slave for a small core.
// Word-addressed data RAM, a TX FIFO feeding a ready/valid consumer,
// a STATUS register with sticky overflow, and a free-running cycle counter.
module data_bus_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    // Word addresses (byte address >> 2) of the register block
    localparam logic [29:0] TX_WADDR     = 30'h0000_0400;
    localparam logic [29:0] STATUS_WADDR = 30'h0000_0401;
    localparam logic [29:0] CYCLE_WADDR  = 30'h0000_0402;

    // ---------------- address decode ----------------
    logic [29:0]    word_addr;
    logic           sel_ram;
    logic           sel_tx;
    logic           sel_status;
    logic           sel_cycle;
    logic [RAW-1:0] ram_idx;
    logic           unused_addr_bits;

    assign word_addr  = data_addr[31:2];
    assign sel_ram    = (data_addr[31:8] == 24'd0);
    assign sel_tx     = (word_addr == TX_WADDR);
    assign sel_status = (word_addr == STATUS_WADDR);
    assign sel_cycle  = (word_addr == CYCLE_WADDR);
    // RAM index wraps modulo RAM_WORDS inside the 256-byte window
    assign ram_idx    = data_addr[2 +: RAW];
    // Byte-lane bits are ignored: word access only
    assign unused_addr_bits = ^data_addr[7:0];

    logic wr_ram;
    logic wr_status;
    logic wr_cycle;
    logic push_req;

    assign wr_ram    = mem_write & sel_ram;
    assign wr_status = mem_write & sel_status;
    assign wr_cycle  = mem_write & sel_cycle;
    assign push_req  = mem_write & sel_tx;

    // ---------------- data RAM ----------------
    logic [31:0] ram [RAM_WORDS];

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= write_data;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;
    logic          overflow_reg;
    logic          is_full;
    logic          pop;
    logic          push_ok;

    assign is_full   = (count_reg == DEPTH_C);
    assign out_valid = (count_reg != '0);
    assign out_data  = fifo_mem[rd_ptr_reg];
    assign pop       = out_valid & out_ready;
    // When full, a push is only accepted if the head leaves in the same cycle
    assign push_ok   = push_req & (~is_full | pop);

    // FIFO storage; when full with a simultaneous pop, wr_ptr equals rd_ptr and
    // the departing head slot is reused for the new tail word
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= write_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && is_full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_status && write_data[8]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cycle_reg;

    // Free-running counter; a bus write loads it instead of incrementing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_reg <= 32'd0;
        end else if (wr_cycle) begin
            cycle_reg <= write_data;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    // ---------------- read mux ----------------
    logic [2:0]  count_lo;
    logic [31:0] status_word;

    assign count_lo    = 3'(count_reg);
    assign status_word = {23'd0, overflow_reg, 3'd0, count_lo, ~out_valid, is_full};

    // Combinational load path; TX_DATA and unmapped addresses read as zero
    always_comb begin
        read_data = 32'd0;
        if (sel_ram) begin
            read_data = ram[ram_idx];
        end else if (sel_status) begin
            read_data = status_word;
        end else if (sel_cycle) begin
            read_data = cycle_reg;
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed, table-driven bench for data_bus_responder.
// Each vector drives the bus on the falling edge, checks combinational
// outputs just after, and lets the next rising edge commit any write.
module tb_data_bus_responder;

    localparam logic [31:0] A_TX     = 32'h0000_1000;
    localparam logic [31:0] A_STATUS = 32'h0000_1004;
    localparam logic [31:0] A_CYCLE  = 32'h0000_1008;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_vec  = 0;
    int n_fail = 0;

    data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        c_rd;
        logic [31:0] exp_rd;
        logic        exp_v;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic rdy, input logic c_rd,
                                input logic [31:0] exp_rd, input logic exp_v,
                                input logic [31:0] exp_od);
        vec_t v;
        v.name = nm; v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy;
        v.c_rd = c_rd; v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_od = exp_od;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rdy);
        mem_write  = we;
        data_addr  = addr;
        write_data = wd;
        out_ready  = rdy;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, A_STATUS, 32'd0, 1'b0);

        // name, we, addr, wdata, ready, check_rd, exp_rd, exp_valid, exp_out_data
        vecs.push_back(mk("ram_wr_10",   1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 32'h0));
        vecs.push_back(mk("ram_wr_14",   1, 32'h14, 32'h1234_5678, 0, 0, 32'h0, 0, 32'h0));
        vecs.push_back(mk("ram_rd_10",   0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0));
        vecs.push_back(mk("ram_rd_14",   0, 32'h14, 32'h0, 0, 1, 32'h1234_5678, 0, 32'h0));
        vecs.push_back(mk("ram_rd_13",   0, 32'h13, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0));
        vecs.push_back(mk("unmap_110",   0, 32'h110, 32'h0, 0, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("tx_rd_zero",  0, A_TX, 32'h0, 0, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("stat_empty",  0, A_STATUS, 32'h0, 0, 1, 32'h2, 0, 32'h0));
        // fill: first push with ready=1 while empty must only enqueue
        vecs.push_back(mk("push1",       1, A_TX, 32'd1, 1, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("push2",       1, A_TX, 32'd2, 0, 1, 32'h0, 1, 32'd1));
        vecs.push_back(mk("push3",       1, A_TX, 32'd3, 0, 1, 32'h0, 1, 32'd1));
        vecs.push_back(mk("push4",       1, A_TX, 32'd4, 0, 1, 32'h0, 1, 32'd1));
        vecs.push_back(mk("push5_drop",  1, A_TX, 32'd5, 0, 1, 32'h0, 1, 32'd1));
        vecs.push_back(mk("stat_ovf",    0, A_STATUS, 32'h0, 0, 1, 32'h111, 1, 32'd1));
        vecs.push_back(mk("pop1",        0, A_STATUS, 32'h0, 1, 1, 32'h111, 1, 32'd1));
        vecs.push_back(mk("pop2",        0, A_STATUS, 32'h0, 1, 1, 32'h10C, 1, 32'd2));
        vecs.push_back(mk("pop3",        0, A_STATUS, 32'h0, 1, 1, 32'h108, 1, 32'd3));
        vecs.push_back(mk("pop4",        0, A_STATUS, 32'h0, 1, 1, 32'h104, 1, 32'd4));
        vecs.push_back(mk("drained",     0, A_STATUS, 32'h0, 0, 1, 32'h102, 0, 32'h0));
        // bit 8 clear: overflow must stay
        vecs.push_back(mk("st_wr_noclr", 1, A_STATUS, 32'h0FF, 0, 1, 32'h102, 0, 32'h0));
        vecs.push_back(mk("st_wr_clr",   1, A_STATUS, 32'h100, 0, 1, 32'h102, 0, 32'h0));
        vecs.push_back(mk("stat_clr",    0, A_STATUS, 32'h0, 0, 1, 32'h002, 0, 32'h0));
        // refill to full across the pointer wrap, then push+pop at full
        vecs.push_back(mk("push5",       1, A_TX, 32'd5, 0, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("push6",       1, A_TX, 32'd6, 0, 1, 32'h0, 1, 32'd5));
        vecs.push_back(mk("push7",       1, A_TX, 32'd7, 0, 1, 32'h0, 1, 32'd5));
        vecs.push_back(mk("push8",       1, A_TX, 32'd8, 0, 1, 32'h0, 1, 32'd5));
        vecs.push_back(mk("stat_full",   0, A_STATUS, 32'h0, 0, 1, 32'h011, 1, 32'd5));
        vecs.push_back(mk("push9_pop",   1, A_TX, 32'd9, 1, 1, 32'h0, 1, 32'd5));
        vecs.push_back(mk("full_noovf",  0, A_STATUS, 32'h0, 0, 1, 32'h011, 1, 32'd6));
        vecs.push_back(mk("pop6",        0, A_STATUS, 32'h0, 1, 1, 32'h011, 1, 32'd6));
        vecs.push_back(mk("pop7",        0, A_STATUS, 32'h0, 1, 1, 32'h00C, 1, 32'd7));
        vecs.push_back(mk("pop8",        0, A_STATUS, 32'h0, 1, 1, 32'h008, 1, 32'd8));
        vecs.push_back(mk("pop9_tail",   0, A_STATUS, 32'h0, 1, 1, 32'h004, 1, 32'd9));
        vecs.push_back(mk("empty_again", 0, A_STATUS, 32'h0, 0, 1, 32'h002, 0, 32'h0));
        // unmapped writes leave RAM and FIFO alone
        vecs.push_back(mk("unmap_wr",    1, 32'h2000, 32'hAAAA_AAAA, 0, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("unmap_wr2",   1, 32'h2010, 32'hAAAA_AAAA, 0, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("unmap_rd",    0, 32'h2000, 32'h0, 0, 1, 32'h0, 0, 32'h0));
        vecs.push_back(mk("ram_keep_10", 0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0));
        vecs.push_back(mk("ram_keep_14", 0, 32'h14, 32'h0, 0, 1, 32'h1234_5678, 0, 32'h0));
        vecs.push_back(mk("fifo_keep",   0, A_STATUS, 32'h0, 0, 1, 32'h002, 0, 32'h0));

        // reset values while held in reset
        #12;
        chk("rst_status", read_data, 32'h2);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        data_addr = A_CYCLE;
        #1;
        chk("rst_cycle", read_data, 32'd0);

        // release between edges; counter first increments on the next rising edge
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("cycle_first", read_data, 32'd1);
        $display("txn reset_release cycle=%h", read_data);

        // table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
            #1;
            if (vecs[i].c_rd) chk({vecs[i].name, ".rd"}, read_data, vecs[i].exp_rd);
            chk({vecs[i].name, ".valid"}, {31'd0, out_valid}, {31'd0, vecs[i].exp_v});
            if (vecs[i].exp_v) chk({vecs[i].name, ".data"}, out_data, vecs[i].exp_od);
            $display("txn %0d %s we=%0b addr=%h wd=%h rdy=%0b rd=%h valid=%0b od=%h",
                     i, vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy,
                     read_data, out_valid, out_data);
        end

        // counter load and wrap
        @(negedge clk);
        drive(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        drive(1'b0, A_CYCLE, 32'd0, 1'b0);
        #1;
        chk("cycle_load", read_data, 32'hFFFF_FFFE);
        $display("txn cycle rd=%h", read_data);
        @(negedge clk);
        #1;
        chk("cycle_max", read_data, 32'hFFFF_FFFF);
        $display("txn cycle rd=%h", read_data);
        @(negedge clk);
        #1;
        chk("cycle_wrap", read_data, 32'd0);
        $display("txn cycle rd=%h", read_data);
        // an unmapped write must not disturb the counter
        @(negedge clk);
        drive(1'b1, 32'h2000, 32'hAAAA_AAAA, 1'b0);
        @(negedge clk);
        drive(1'b0, A_CYCLE, 32'd0, 1'b0);
        #1;
        chk("cycle_unmap", read_data, 32'd2);
        $display("txn cycle rd=%h", read_data);

        // asynchronous reset with three words queued
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b1, A_TX, 32'(k + 32'h40), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, A_STATUS, 32'd0, 1'b0);
        #1;
        chk("pre_rst_status", read_data, 32'h00C);
        chk("pre_rst_data", out_data, 32'h41);
        out_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_status", read_data, 32'h2);
        data_addr = A_CYCLE;
        #0.5;
        chk("arst_cycle", read_data, 32'd0);
        $display("txn async_reset valid=%0b", out_valid);
        @(negedge clk);
        #1;
        chk("rst_hold_cycle", read_data, 32'd0);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_rel_cycle", read_data, 32'd1);
        chk("rst_rel_valid", {31'd0, out_valid}, 32'd0);
        data_addr = 32'h10;
        #1;
        chk("ram_survives", read_data, 32'hDEAD_BEEF);
        $display("txn post_reset ram=%h", read_data);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
